context_scheduler: RTL and testbench
====================================

// Module: context_scheduler
// PURPOSE
//  Preemptive round-robin scheduler that drives the program counter's jump inputs.
//  Counts a time quantum while a user process runs and saves the process's next PC.
//  Redirects the PC to the OS handler, then restarts the next active process at its saved PC.
//  Sits beside the PC: PC jump/jump_context_exchange are ORed with ctx_jump; address is muxed with ctx_address.
// PARAMETERS
//  ADDR_W      12    PC width
//  NPROC       4     number of process slots (power of 2, 2..8)
//  QUANTUM_W   8     quantum counter width
//  QUANTUM_RST 16    quantum loaded at reset
//  OS_ENTRY    1083  OS context-exchange handler address
//  PROC_BASE   0     reset saved-PC of slot 0
//  PROC_STRIDE 64    reset saved-PC spacing: slot i = PROC_BASE + i*PROC_STRIDE (mod 2^ADDR_W)
// PORTS
//  clock          in   1          system clock, all state on posedge
//  resetCPU       in   1          asynchronous, active-high reset
//  next_pc        in   ADDR_W     PC's next-address (newPc) this cycle
//  HLT            in   1          CPU halted; freezes quantum countdown
//  sched_en       in   1          scheduling enable (OS-controlled level)
//  quantum_wr     in   1          load quantum_data into quantum register
//  quantum_data   in   QUANTUM_W  new quantum; 0 is treated as 1
//  mask_wr        in   1          load mask_data into active-process mask
//  mask_data      in   NPROC      bit i = slot i runnable
//  resume         in   1          OS handler done; dispatch next process (1-cycle pulse)
//  ctx_jump       out  1          1-cycle PC redirect strobe
//  ctx_address    out  ADDR_W     redirect target, valid while ctx_jump=1
//  ctx_to_os      out  1          qualifies ctx_jump: 1 = entry to OS_ENTRY (drive jump_context_exchange)
//  in_os          out  1          level: OS handler executing
//  cur_proc       out  log2(NPROC) slot currently/last running
// BEHAVIOUR
//  Reset (async): state=IDLE; ctx_jump=0; ctx_to_os=0; ctx_address=0; in_os=0; cur_proc=0;
//   quantum=QUANTUM_RST; mask=1 (slot 0 only); saved_pc[i]=PROC_BASE+i*PROC_STRIDE; count=0.
//  quantum_wr/mask_wr take effect next edge in any state; a new quantum applies at the next reload only.
//  FSM:
//   IDLE : sched_en=1 -> RUN, count<=quantum. Outputs quiet.
//   RUN  : HLT=0 -> count--; HLT=1 -> hold. count==1 and HLT=0 -> SWITCH next cycle.
//          sched_en=0 -> IDLE (no save, no jump); takes priority over expiry in the same cycle.
//   SWITCH (1 cycle): saved_pc[cur_proc]<=next_pc; ctx_jump=1, ctx_to_os=1, ctx_address=OS_ENTRY;
//          -> OS_WAIT. Executes even if sched_en drops this cycle.
//   OS_WAIT: in_os=1; count frozen. resume=1 and mask!=0 -> DISPATCH;
//          resume with mask==0 is ignored; remain OS_WAIT. sched_en=0 -> IDLE, in_os=0.
//   DISPATCH (1 cycle): sel = first set mask bit scanning cur_proc+1, +2, ... wrapping, cur_proc last.
//          cur_proc<=sel; ctx_jump=1, ctx_to_os=0, ctx_address=saved_pc[sel]; count<=quantum; -> RUN.
//  ctx_jump/ctx_to_os/ctx_address are registered (Moore) outputs; each switch/dispatch asserts ctx_jump exactly 1 cycle.
//  Latency: expiry cycle (count==1, HLT=0) -> ctx_jump at OS_ENTRY next cycle; resume -> dispatch jump next cycle.
//  Saved PC is next_pc, so an instruction in flight during SWITCH (branch or jump) completes normally.
//  Count is QUANTUM_W bits. A quantum of 1 switches after 1 unhalted cycle. No wrap: RUN reloads before underflow.
//  cur_proc masked out during its slice keeps running until expiry; it is then skipped on dispatch.
// CONFIGURATION
//  SCHED_YIELD_EN defined: adds input yield_req (1 bit). yield_req=1 in RUN with HLT=0 -> SWITCH next cycle,
//   as on expiry; yield_req with HLT=1 is ignored. Not defined: port absent; only quantum expiry preempts.
// TESTING
//  1 reset, sched_en=1, quantum=4, HLT=0 -> ctx_jump=1, ctx_to_os=1, ctx_address=1083 on 5th cycle after RUN entry.
//  2 mask=4'b1011, cur_proc=0, next_pc=0x123 in SWITCH; resume -> cur_proc=1, ctx_address=64; next slice -> slot 3 at 192; then slot 0 at 0x123.
//  3 quantum=3, HLT high 5 cycles mid-slice -> switch delayed exactly 5 cycles; no ctx_jump while HLT=1.
//  4 mask_wr 0 then resume -> no ctx_jump, in_os stays 1; mask_wr 4'b0100 then resume -> ctx_address=128, cur_proc=2.
//  5 resetCPU pulsed in SWITCH and in OS_WAIT -> outputs 0 immediately, saved_pc table back to 0/64/128/192.
//  6 SCHED_YIELD_EN: quantum=16, yield_req at count 10 -> OS entry next cycle; with HLT=1 -> ignored.

Source files
------------

// File: rtl/context_scheduler.sv
// Preemptive round-robin context scheduler that drives the PC's jump inputs.
// Optional feature: define SCHED_YIELD_EN to add the yield_req voluntary-preemption input.
module context_scheduler #(
    parameter int ADDR_W      = 12,
    parameter int NPROC       = 4,
    parameter int QUANTUM_W   = 8,
    parameter int QUANTUM_RST = 16,
    parameter int OS_ENTRY    = 1083,
    parameter int PROC_BASE   = 0,
    parameter int PROC_STRIDE = 64,
    localparam int CW = (NPROC > 1) ? $clog2(NPROC) : 1
) (
    input  logic                 clock,
    input  logic                 resetCPU,
    input  logic [ADDR_W-1:0]    next_pc,
    input  logic                 HLT,
    input  logic                 sched_en,
    input  logic                 quantum_wr,
    input  logic [QUANTUM_W-1:0] quantum_data,
    input  logic                 mask_wr,
    input  logic [NPROC-1:0]     mask_data,
    input  logic                 resume,
`ifdef SCHED_YIELD_EN
    input  logic                 yield_req,
`endif
    output logic                 ctx_jump,
    output logic [ADDR_W-1:0]    ctx_address,
    output logic                 ctx_to_os,
    output logic                 in_os,
    output logic [CW-1:0]        cur_proc,
    output logic [2:0]           dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        SWITCH   = 3'd2,
        OS_WAIT  = 3'd3,
        DISPATCH = 3'd4
    } state_t;

    state_t               state_q;
    logic [QUANTUM_W-1:0] count_q;
    logic [QUANTUM_W-1:0] quantum_q;
    logic [NPROC-1:0]     mask_q;
    logic [ADDR_W-1:0]    saved_pc_q [NPROC];
    logic [CW-1:0]        cur_proc_q;
    logic                 ctx_jump_q;
    logic                 ctx_to_os_q;
    logic [ADDR_W-1:0]    ctx_address_q;
    logic                 in_os_q;

    logic [CW-1:0]        sel_d;
    logic [CW-1:0]        scan_idx;
    logic                 sel_found;
    logic                 yield_w;

`ifdef SCHED_YIELD_EN
    assign yield_w = yield_req;
`else
    assign yield_w = 1'b0;
`endif

    // Round-robin pick: scan from the slot after cur_proc, wrapping, cur_proc last.
    always_comb begin
        sel_d     = cur_proc_q;
        scan_idx  = cur_proc_q;
        sel_found = 1'b0;
        for (int i = 1; i <= NPROC; i++) begin
            scan_idx = cur_proc_q + CW'(i);
            if (!sel_found && mask_q[scan_idx]) begin
                sel_d     = scan_idx;
                sel_found = 1'b1;
            end
        end
    end

    // ctx_jump/resume are single-cycle strobes with no back-pressure: ctx_jump is
    // asserted for exactly the one cycle spent in SWITCH or DISPATCH, and
    // ctx_address/ctx_to_os are meaningful only while it is high.
    always_ff @(posedge clock or posedge resetCPU) begin
        if (resetCPU) begin
            state_q       <= IDLE;
            count_q       <= '0;
            quantum_q     <= QUANTUM_W'(QUANTUM_RST);
            mask_q        <= NPROC'(1);
            cur_proc_q    <= '0;
            ctx_jump_q    <= 1'b0;
            ctx_to_os_q   <= 1'b0;
            ctx_address_q <= '0;
            in_os_q       <= 1'b0;
            for (int i = 0; i < NPROC; i++) begin
                saved_pc_q[i] <= ADDR_W'(PROC_BASE + i * PROC_STRIDE);
            end
        end else begin
            if (quantum_wr) begin
                quantum_q <= (quantum_data == '0) ? QUANTUM_W'(1) : quantum_data;
            end
            if (mask_wr) begin
                mask_q <= mask_data;
            end

            case (state_q)
                IDLE: begin
                    ctx_jump_q  <= 1'b0;
                    ctx_to_os_q <= 1'b0;
                    in_os_q     <= 1'b0;
                    if (sched_en) begin
                        state_q <= RUN;
                        count_q <= quantum_q;
                    end
                end

                RUN: begin
                    ctx_jump_q <= 1'b0;
                    if (!sched_en) begin
                        state_q <= IDLE;
                    end else if (!HLT) begin
                        count_q <= count_q - QUANTUM_W'(1);
                        if (count_q == QUANTUM_W'(1) || yield_w) begin
                            state_q       <= SWITCH;
                            ctx_jump_q    <= 1'b1;
                            ctx_to_os_q   <= 1'b1;
                            ctx_address_q <= ADDR_W'(OS_ENTRY);
                        end
                    end
                end

                SWITCH: begin
                    // next_pc lets whatever instruction is in flight this cycle complete.
                    saved_pc_q[cur_proc_q] <= next_pc;
                    ctx_jump_q             <= 1'b0;
                    ctx_to_os_q            <= 1'b0;
                    in_os_q                <= 1'b1;
                    state_q                <= OS_WAIT;
                end

                OS_WAIT: begin
                    if (!sched_en) begin
                        state_q <= IDLE;
                        in_os_q <= 1'b0;
                    end else if (resume && (mask_q != '0)) begin
                        state_q       <= DISPATCH;
                        in_os_q       <= 1'b0;
                        cur_proc_q    <= sel_d;
                        ctx_jump_q    <= 1'b1;
                        ctx_to_os_q   <= 1'b0;
                        ctx_address_q <= saved_pc_q[sel_d];
                    end
                end

                DISPATCH: begin
                    ctx_jump_q <= 1'b0;
                    count_q    <= quantum_q;
                    state_q    <= RUN;
                end

                default: begin
                    state_q    <= IDLE;
                    ctx_jump_q <= 1'b0;
                    in_os_q    <= 1'b0;
                end
            endcase
        end
    end

    assign ctx_jump    = ctx_jump_q;
    assign ctx_address = ctx_address_q;
    assign ctx_to_os   = ctx_to_os_q;
    assign in_os       = in_os_q;
    assign cur_proc    = cur_proc_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_context_scheduler.sv
// Directed-vector bench for context_scheduler: slicing, round-robin dispatch, halt, mask and reset.
module tb_context_scheduler;

    localparam int ADDR_W    = 12;
    localparam int NPROC     = 4;
    localparam int QUANTUM_W = 8;
    localparam int CW        = 2;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RUN      = 3'd1;
    localparam logic [2:0] S_SWITCH   = 3'd2;
    localparam logic [2:0] S_OS_WAIT  = 3'd3;
    localparam logic [2:0] S_DISPATCH = 3'd4;

    logic                 clock = 1'b0;
    logic                 resetCPU;
    logic [ADDR_W-1:0]    next_pc;
    logic                 HLT;
    logic                 sched_en;
    logic                 quantum_wr;
    logic [QUANTUM_W-1:0] quantum_data;
    logic                 mask_wr;
    logic [NPROC-1:0]     mask_data;
    logic                 resume;
`ifdef SCHED_YIELD_EN
    logic                 yield_req;
`endif
    logic                 ctx_jump;
    logic [ADDR_W-1:0]    ctx_address;
    logic                 ctx_to_os;
    logic                 in_os;
    logic [CW-1:0]        cur_proc;
    logic [2:0]           dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    context_scheduler dut (
        .clock        (clock),
        .resetCPU     (resetCPU),
        .next_pc      (next_pc),
        .HLT          (HLT),
        .sched_en     (sched_en),
        .quantum_wr   (quantum_wr),
        .quantum_data (quantum_data),
        .mask_wr      (mask_wr),
        .mask_data    (mask_data),
        .resume       (resume),
`ifdef SCHED_YIELD_EN
        .yield_req    (yield_req),
`endif
        .ctx_jump     (ctx_jump),
        .ctx_address  (ctx_address),
        .ctx_to_os    (ctx_to_os),
        .in_os        (in_os),
        .cur_proc     (cur_proc),
        .dbg_state_o  (dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic wait_jump(input int max_cycles, output int n);
        n = 0;
        while (ctx_jump !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        if (ctx_jump !== 1'b1) check_eq("jump_timeout", 32'(ctx_jump), 32'd1);
    endtask

    task automatic pulse_resume();
        resume = 1'b1;
        tick();
        resume = 1'b0;
    endtask

    task automatic check_os_jump(input string tag);
        check_eq({tag, "_jump"},  32'(ctx_jump),    32'd1);
        check_eq({tag, "_to_os"}, 32'(ctx_to_os),   32'd1);
        check_eq({tag, "_addr"},  32'(ctx_address), 32'd1083);
    endtask

    task automatic check_dispatch(input string tag, input int slot, input int addr);
        check_eq({tag, "_jump"},  32'(ctx_jump),    32'd1);
        check_eq({tag, "_to_os"}, 32'(ctx_to_os),   32'd0);
        check_eq({tag, "_addr"},  32'(ctx_address), 32'(addr));
        check_eq({tag, "_cur"},   32'(cur_proc),    32'(slot));
    endtask

    // scoreboard: dispatch targets expected after the post-reset table check
    logic [ADDR_W-1:0] exp_q[$];

    initial begin
        int n;
        int halt_jumps;
        logic [ADDR_W-1:0] exp_addr;

        resetCPU = 1'b1; next_pc = '0; HLT = 1'b0; sched_en = 1'b0;
        quantum_wr = 1'b0; quantum_data = '0; mask_wr = 1'b0; mask_data = '0; resume = 1'b0;
`ifdef SCHED_YIELD_EN
        yield_req = 1'b0;
`endif
        @(negedge clock);
        check_eq("rst_jump",  32'(ctx_jump),    32'd0);
        check_eq("rst_addr",  32'(ctx_address), 32'd0);
        check_eq("rst_in_os", 32'(in_os),       32'd0);
        check_eq("rst_cur",   32'(cur_proc),    32'd0);
        check_eq("rst_state", 32'(dbg_state),   32'(S_IDLE));
        resetCPU = 1'b0;
        tick();

        // Test 1: quantum 4, OS entry on the 5th cycle counting RUN entry as the 1st
        quantum_wr = 1'b1; quantum_data = 8'd4;
        mask_wr = 1'b1; mask_data = 4'b1011;
        next_pc = 12'h123;
        tick();
        quantum_wr = 1'b0; mask_wr = 1'b0;
        check_eq("idle_quiet", 32'(dbg_state), 32'(S_IDLE));
        sched_en = 1'b1;
        tick();
        check_eq("t1_run", 32'(dbg_state), 32'(S_RUN));
        wait_jump(20, n);
        check_eq("t1_latency", 32'(n), 32'd4);
        check_os_jump("t1");

        // Test 2: round robin over mask 1011: 1 @64, 3 @192, then 0 @0x123
        tick();
        check_eq("t2_os_jump", 32'(ctx_jump), 32'd0);
        check_eq("t2_in_os",   32'(in_os),    32'd1);
        pulse_resume();
        check_dispatch("t2_s1", 1, 64);
        check_eq("t2_disp_in_os", 32'(in_os), 32'd0);
        next_pc = 12'h2AA;
        tick();
        check_eq("t2_run_quiet", 32'(ctx_jump), 32'd0);
        wait_jump(20, n);
        check_eq("t2_latency", 32'(n), 32'd4);
        check_os_jump("t2b");
        tick();
        pulse_resume();
        check_dispatch("t2_s3", 3, 192);
        tick();
        wait_jump(20, n);
        tick();
        quantum_wr = 1'b1; quantum_data = 8'd3;
        tick();
        quantum_wr = 1'b0;
        pulse_resume();
        check_dispatch("t2_s0", 0, 12'h123);

        // Test 3: quantum 3 with 5 halted cycles mid-slice
        tick();
        tick();
        HLT = 1'b1;
        halt_jumps = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ctx_jump === 1'b1) halt_jumps++;
        end
        check_eq("t3_no_jump_hlt", 32'(halt_jumps), 32'd0);
        HLT = 1'b0;
        wait_jump(20, n);
        check_eq("t3_after_hlt", 32'(n), 32'd2);
        check_os_jump("t3");

        // Test 4: resume with empty mask is ignored
        tick();
        mask_wr = 1'b1; mask_data = 4'b0000;
        tick();
        mask_wr = 1'b0;
        pulse_resume();
        check_eq("t4_no_jump",  32'(ctx_jump),  32'd0);
        check_eq("t4_in_os",    32'(in_os),     32'd1);
        check_eq("t4_state",    32'(dbg_state), 32'(S_OS_WAIT));
        mask_wr = 1'b1; mask_data = 4'b0100;
        tick();
        mask_wr = 1'b0;
        pulse_resume();
        check_dispatch("t4_s2", 2, 128);

        // Test 5a: reset while in SWITCH
        tick();
        wait_jump(20, n);
        check_eq("t5_q3_latency", 32'(n), 32'd3);
        check_eq("t5_in_switch",  32'(dbg_state), 32'(S_SWITCH));
        resetCPU = 1'b1;
        #1;
        check_eq("t5a_jump",  32'(ctx_jump),    32'd0);
        check_eq("t5a_to_os", 32'(ctx_to_os),   32'd0);
        check_eq("t5a_addr",  32'(ctx_address), 32'd0);
        check_eq("t5a_state", 32'(dbg_state),   32'(S_IDLE));
        #1;
        resetCPU = 1'b0;
        tick();
        // Reset quantum of 16 and mask of slot 0 only are back in effect
        wait_jump(40, n);
        check_eq("t5_qrst_latency", 32'(n), 32'd16);
        tick();
        check_eq("t5_in_os_pre", 32'(in_os), 32'd1);

        // Test 5b: reset while in OS_WAIT
        resetCPU = 1'b1;
        #1;
        check_eq("t5b_in_os", 32'(in_os),     32'd0);
        check_eq("t5b_cur",   32'(cur_proc),  32'd0);
        check_eq("t5b_state", 32'(dbg_state), 32'(S_IDLE));
        #1;
        resetCPU = 1'b0;
        sched_en = 1'b0;
        tick();
        // quantum 0 behaves as 1; saved-PC table must read back as 64/128/192
        quantum_wr = 1'b1; quantum_data = 8'd0;
        mask_wr = 1'b1; mask_data = 4'b1111;
        tick();
        quantum_wr = 1'b0; mask_wr = 1'b0;
        next_pc = 12'h5A5;
        sched_en = 1'b1;
        exp_q.push_back(12'd64);
        exp_q.push_back(12'd128);
        exp_q.push_back(12'd192);
        exp_q.push_back(12'h5A5);
        tick();
        for (int k = 1; k <= 4; k++) begin
            wait_jump(10, n);
            check_eq($sformatf("t5_q1_lat_%0d", k), 32'(n), 32'd1);
            tick();
            pulse_resume();
            exp_addr = exp_q.pop_front();
            check_dispatch($sformatf("t5_slot%0d", k % 4), k % 4, 32'(exp_addr));
            tick();
        end

`ifdef SCHED_YIELD_EN
        // Test 6: yield at count 10 preempts; yield while halted is ignored
        wait_jump(10, n);
        tick();
        quantum_wr = 1'b1; quantum_data = 8'd16;
        tick();
        quantum_wr = 1'b0;
        pulse_resume();
        tick();
        for (int i = 0; i < 6; i++) tick();
        HLT = 1'b1; yield_req = 1'b1;
        tick();
        check_eq("t6_yield_hlt_jump",  32'(ctx_jump),  32'd0);
        check_eq("t6_yield_hlt_state", 32'(dbg_state), 32'(S_RUN));
        HLT = 1'b0;
        tick();
        yield_req = 1'b0;
        check_os_jump("t6");
`endif

        // final report
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
